led_panel_pixel_client: RTL and testbench



---
 rtl/led_panel_pixel_client.sv | 150 +++++++++++++++
 tb/tb_led_panel_pixel_client.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_panel_pixel_client.sv
// Double-buffered LED frame memory with an Avalon-MM pixel/control slave and a two-stage bit-plane scan path.
// Define LED_CLIENT_FILL_EN to include the whole-backbuffer fill engine and the fill colour register.
module led_panel_pixel_client #(
  parameter int DISPLAY_ROWS_LINES = 4,
  parameter int DISPLAY_COLS_LINES = 6,
  parameter int COLOR_BITS         = 8,
  localparam int PA = DISPLAY_ROWS_LINES + DISPLAY_COLS_LINES,
  localparam int AW = PA + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW:0]   s1_address,
  input  logic          s1_write,
  input  logic [31:0]   s1_writedata,
  input  logic          s1_read,
  output logic [31:0]   s1_readdata,
  output logic          s1_waitrequest,
  input  logic [PA-1:0] memAddrMst,
  input  logic [2:0]    bitplaneMst,
  input  logic          backbufferMst,
  output logic          R1,
  output logic          G1,
  output logic          B1,
  output logic          R2,
  output logic          G2,
  output logic          B2
);
  localparam int PW    = 3 * COLOR_BITS;
  localparam int DEPTH = 2 ** AW;

  logic [PW-1:0] ram_top [DEPTH];
  logic [PW-1:0] ram_bot [DEPTH];

  logic          busy;
  logic          fbuf;
  logic [PA-1:0] fill_cnt;
  logic [PW-1:0] fill_color;
  logic          pix_wr;
  logic          unused_wdata;

  assign pix_wr       = s1_write && !s1_address[AW] && !s1_waitrequest;
  assign unused_wdata = ^s1_writedata[31:PW];

  function automatic logic [2:0] plane_bits(input logic [PW-1:0] px, input logic [2:0] plane);
    logic [PW-1:0] sh;
    sh = px >> plane;
    if (int'(plane) >= COLOR_BITS) return 3'b000;
    return {sh[2*COLOR_BITS], sh[COLOR_BITS], sh[0]};
  endfunction

`ifdef LED_CLIENT_FILL_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0] state;
  logic       ctrl_wr;
  logic       start_wr;

  assign busy           = (state == ST_FILL);
  assign s1_waitrequest = s1_write && busy;
  assign ctrl_wr        = s1_write && s1_address[AW] && !s1_waitrequest;
  assign start_wr       = ctrl_wr && !s1_address[0] && s1_writedata[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      fbuf       <= 1'b0;
      fill_cnt   <= '0;
      fill_color <= '0;
    end else begin
      if (ctrl_wr && s1_address[0]) fill_color <= s1_writedata[PW-1:0];
      case (state)
        ST_IDLE: begin
          if (start_wr) begin
            state    <= ST_FILL;
            fbuf     <= backbufferMst;
            fill_cnt <= '0;
          end
        end
        default: begin
          fill_cnt <= fill_cnt + PA'(1);
          if (fill_cnt == '1) state <= ST_IDLE;
        end
      endcase
    end
  end
`else
  assign busy           = 1'b0;
  assign s1_waitrequest = 1'b0;
  assign fbuf           = 1'b0;
  assign fill_cnt       = '0;
  assign fill_color     = '0;
`endif

  // The fill engine owns both RAM write ports while busy; slave writes are stalled then.
  logic          we_top, we_bot;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;

  always_comb begin
    we_top  = 1'b0;
    we_bot  = 1'b0;
    wr_addr = {backbufferMst, s1_address[PA-1:0]};
    wr_data = s1_writedata[PW-1:0];
    if (busy) begin
      we_top  = 1'b1;
      we_bot  = 1'b1;
      wr_addr = {fbuf, fill_cnt};
      wr_data = fill_color;
    end else if (pix_wr) begin
      we_top = !s1_address[AW-1];
      we_bot = s1_address[AW-1];
    end
  end

  always_ff @(posedge clock) begin
    if (we_top) ram_top[wr_addr] <= wr_data;
    if (we_bot) ram_bot[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_readdata <= '0;
    end else if (s1_read && s1_address[AW]) begin
      s1_readdata <= s1_address[0] ? 32'(fill_color) : {30'b0, backbufferMst, busy};
    end else begin
      s1_readdata <= '0;
    end
  end

  // Stage p0: front-buffer RAM read, plane carried alongside
  logic [PW-1:0] top_p0, bot_p0;
  logic [2:0]    plane_p0;

  always_ff @(posedge clock) begin
    top_p0   <= ram_top[{~backbufferMst, memAddrMst}];
    bot_p0   <= ram_bot[{~backbufferMst, memAddrMst}];
    plane_p0 <= bitplaneMst;
  end

  // Stage p1: bit-plane select onto the panel data lines
  always_ff @(posedge clock) begin
    if (reset) begin
      {R1, G1, B1, R2, G2, B2} <= '0;
    end else begin
      {R1, G1, B1} <= plane_bits(top_p0, plane_p0);
      {R2, G2, B2} <= plane_bits(bot_p0, plane_p0);
    end
  end
endmodule

// File: tb/tb_led_panel_pixel_client.sv
// Bench for led_panel_pixel_client: directed vector table plus random pixels checked against a frame-buffer model.
// Fill-engine checks are included when LED_CLIENT_FILL_EN is defined for the build.
module tb_led_panel_pixel_client;
  localparam int PA   = 10;
  localparam int NPIX = 1 << PA;
  localparam int CB   = 8;
  localparam int PW   = 3 * CB;
  localparam logic [11:0] CTRL0 = 12'h800;
  localparam logic [11:0] CTRL1 = 12'h801;

  logic          clock = 1'b0;
  logic          reset;
  logic [11:0]   s1_address;
  logic          s1_write;
  logic [31:0]   s1_writedata;
  logic          s1_read;
  logic [31:0]   s1_readdata;
  logic          s1_waitrequest;
  logic [PA-1:0] memAddrMst;
  logic [2:0]    bitplaneMst;
  logic          backbufferMst;
  logic          R1, G1, B1, R2, G2, B2;

  int checks = 0;
  int errors = 0;
  int mdl_top [2*NPIX];
  int mdl_bot [2*NPIX];

  typedef struct {
    int         top_px;
    int         bot_px;
    int         idx;
    int         plane;
    logic [5:0] rgb;
  } vec_t;
  vec_t vecs [6];

  led_panel_pixel_client dut (
    .clock(clock), .reset(reset),
    .s1_address(s1_address), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_read(s1_read), .s1_readdata(s1_readdata), .s1_waitrequest(s1_waitrequest),
    .memAddrMst(memAddrMst), .bitplaneMst(bitplaneMst), .backbufferMst(backbufferMst),
    .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit bit_at(input int v, input int pos);
    return ((v / (1 << pos)) % 2) != 0;
  endfunction

  // The panel shows the buffer that is not the backbuffer.
  function automatic logic [5:0] exp_rgb(input int a, input int plane, input logic bb);
    int slot, t, b;
    slot = (bb ? 0 : NPIX) + a;
    t = mdl_top[slot];
    b = mdl_bot[slot];
    if (plane >= CB) return 6'd0;
    return {bit_at(t, 2*CB + plane), bit_at(t, CB + plane), bit_at(t, plane),
            bit_at(b, 2*CB + plane), bit_at(b, CB + plane), bit_at(b, plane)};
  endfunction

  function automatic void model_fill(input int buf_sel, input int first, input int last, input int colour);
    for (int i = first; i <= last; i++) begin
      mdl_top[buf_sel*NPIX + i] = colour % (1 << PW);
      mdl_bot[buf_sel*NPIX + i] = colour % (1 << PW);
    end
  endfunction

  task automatic avm_write(input logic [11:0] a, input logic [31:0] d, output int stalls);
    s1_address = a;
    s1_writedata = d;
    s1_write = 1'b1;
    stalls = 0;
    #1;
    while (s1_waitrequest && stalls < 4000) begin
      @(posedge clock);
      #2;
      stalls++;
    end
    @(posedge clock);
    #1;
    s1_write = 1'b0;
  endtask

  task automatic avm_read(input logic [11:0] a, output logic [31:0] d);
    s1_address = a;
    s1_read = 1'b1;
    step();
    s1_read = 1'b0;
    d = s1_readdata;
  endtask

  task automatic pix_write(input int half, input int idx, input logic [31:0] data);
    int st, slot;
    avm_write(12'(half * NPIX + idx), data, st);
    slot = (backbufferMst ? NPIX : 0) + idx;
    if (half != 0) mdl_bot[slot] = int'(data % (1 << PW));
    else           mdl_top[slot] = int'(data % (1 << PW));
  endtask

  // Pipelined scan: one address per clock, each result compared two clocks after issue.
  task automatic scan_run(input string name, input logic bb, input int start, input int count,
                          input int stride, input bit rnd);
    logic [5:0] q [$];
    logic [5:0] e;
    backbufferMst = bb;
    for (int i = 0; i <= count; i++) begin
      if (i < count) begin
        int a, p;
        a = rnd ? int'($urandom_range(NPIX - 1)) : (start + i * stride) % NPIX;
        p = int'($urandom_range(7));
        memAddrMst = a[PA-1:0];
        bitplaneMst = p[2:0];
        q.push_back(exp_rgb(a, p, bb));
      end
      step();
      if (i >= 1) begin
        e = q.pop_front();
        check(name, {26'b0, R1, G1, B1, R2, G2, B2}, {26'b0, e});
      end
    end
  endtask

  task automatic count_busy(input int flip_at, output int n);
    int guard;
    guard = 0;
    n = 0;
    s1_address = CTRL0;
    s1_read = 1'b1;
    while (guard < 4000) begin
      step();
      guard++;
      if (!s1_readdata[0]) break;
      n++;
      if (n == flip_at) backbufferMst = ~backbufferMst;
    end
    s1_read = 1'b0;
  endtask

  logic [31:0] rd;
  int st, nb, colour, pdata;

  initial begin
    vecs[0] = '{top_px: 32'h00FF0080, bot_px: 0,            idx: 5,    plane: 7, rgb: 6'b101000};
    vecs[1] = '{top_px: 32'h00FF0080, bot_px: 0,            idx: 5,    plane: 0, rgb: 6'b100000};
    vecs[2] = '{top_px: 0,            bot_px: 32'h00010203, idx: 1023, plane: 0, rgb: 6'b000101};
    vecs[3] = '{top_px: 0,            bot_px: 32'h00010203, idx: 1023, plane: 1, rgb: 6'b000011};
    vecs[4] = '{top_px: 32'h00FFFFFF, bot_px: 32'h00FFFFFF, idx: 0,    plane: 3, rgb: 6'b111111};
    vecs[5] = '{top_px: 32'h00AA5500, bot_px: 32'h0055AA00, idx: 512,  plane: 1, rgb: 6'b100010};

    reset = 1'b1;
    s1_address = '0; s1_write = 1'b0; s1_writedata = '0; s1_read = 1'b0;
    memAddrMst = '0; bitplaneMst = '0; backbufferMst = 1'b1;
    repeat (3) step();
    check("reset_rgb", {26'b0, R1, G1, B1, R2, G2, B2}, 32'd0);
    check("reset_readdata", s1_readdata, 32'd0);
    check("reset_waitrequest", {31'b0, s1_waitrequest}, 32'd0);
    reset = 1'b0;
    step();
    avm_read(CTRL1, rd);
    check("reset_fill_colour", rd, 32'd0);
    avm_read(CTRL0, rd);
    check("reset_ctrl0", rd, 32'd2);

    for (int b = 0; b < 2; b++) begin
      backbufferMst = b[0];
      for (int idx = 0; idx < NPIX; idx++) begin
        pix_write(0, idx, $urandom);
        pix_write(1, idx, $urandom);
      end
    end

    foreach (vecs[k]) begin
      backbufferMst = 1'b0;
      pix_write(0, vecs[k].idx, vecs[k].top_px);
      pix_write(1, vecs[k].idx, vecs[k].bot_px);
      backbufferMst = 1'b1;
      memAddrMst = vecs[k].idx[PA-1:0];
      bitplaneMst = vecs[k].plane[2:0];
      step();
      step();
      check($sformatf("vec%0d", k), {26'b0, R1, G1, B1, R2, G2, B2}, {26'b0, vecs[k].rgb});
    end

    avm_read(12'h005, rd);
    check("pixel_read_zero", rd, 32'd0);
    backbufferMst = 1'b0;
    avm_read(CTRL0, rd);
    check("ctrl0_bb0", rd, 32'd0);

    scan_run("scan_rand_bb1", 1'b1, 0, 400, 1, 1'b1);
    scan_run("scan_rand_bb0", 1'b0, 0, 400, 1, 1'b1);

`ifdef LED_CLIENT_FILL_EN
    avm_write(CTRL1, 32'h0000FF00, st);
    avm_read(CTRL1, rd);
    check("fill_colour_rb", rd, 32'h0000FF00);
    backbufferMst = 1'b1;
    avm_write(CTRL0, 32'd1, st);
    check("start_no_stall", st, 0);
    count_busy(300, nb);
    check("fill1_busy_cycles", nb, 1024);
    model_fill(1, 0, NPIX - 1, 32'h0000FF00);
    scan_run("fill1_scan", 1'b0, 0, NPIX, 1, 1'b0);
    scan_run("fill1_other_buf", 1'b1, 0, 300, 1, 1'b1);

    colour = int'($urandom % (1 << PW));
    pdata = int'($urandom % (1 << PW));
    avm_write(CTRL1, colour, st);
    backbufferMst = 1'b0;
    avm_write(CTRL0, 32'd1, st);
    avm_write(12'(NPIX + 9), pdata, st);
    check("fill2_write_stall", st, 1024);
    model_fill(0, 0, NPIX - 1, colour);
    mdl_bot[9] = pdata;
    scan_run("fill2_scan", 1'b1, 0, NPIX, 1, 1'b0);

    avm_write(CTRL1, 32'h000000FF, st);
    backbufferMst = 1'b1;
    avm_write(CTRL0, 32'd1, st);
    backbufferMst = 1'b0;
    memAddrMst = '0;
    bitplaneMst = '0;
    repeat (100) step();
    reset = 1'b1;
    step();
    check("abort_rgb", {26'b0, R1, G1, B1, R2, G2, B2}, 32'd0);
    reset = 1'b0;
    avm_read(CTRL0, rd);
    check("abort_busy", rd, 32'd0);
    avm_read(CTRL1, rd);
    check("abort_colour", rd, 32'd0);
    model_fill(1, 0, 99, 32'h000000FF);
    scan_run("abort_partial", 1'b0, 50, 2, 450, 1'b0);

    avm_write(CTRL1, 32'h00FF0000, st);
    backbufferMst = 1'b1;
    avm_write(CTRL0, 32'd1, st);
    count_busy(0, nb);
    check("refill_busy_cycles", nb, 1024);
    model_fill(1, 0, NPIX - 1, 32'h00FF0000);
    scan_run("refill_scan", 1'b0, 0, NPIX, 1, 1'b0);
`else
    backbufferMst = 1'b1;
    avm_write(CTRL0, 32'd1, st);
    check("nofill_start_stall", st, 0);
    avm_read(CTRL0, rd);
    check("nofill_busy", rd, 32'd2);
    avm_write(CTRL1, 32'h00ABCDEF, st);
    check("nofill_colour_stall", st, 0);
    avm_read(CTRL1, rd);
    check("nofill_colour_rb", rd, 32'd0);
    scan_run("nofill_scan_bb1", 1'b1, 0, NPIX, 1, 1'b0);
    scan_run("nofill_scan_bb0", 1'b0, 0, NPIX, 1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
